// File: rtl/ram_fifo.sv
// ram_fifo: single-clock FIFO on an inferred block-RAM array with a registered
// read port. Supports standard and first-word-fall-through read modes, an
// occupancy count, programmable almost flags and overflow/underflow pulses.
module ram_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] mid_data_q, mid_data_d;
  logic                  mid_valid_q, mid_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd;
  logic                  mid_to_out;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] waddr;

  assign raddr = rptr_q[ADDR_WIDTH-1:0];
  assign waddr = wptr_q[ADDR_WIDTH-1:0];

  // Next-state: acceptance from pre-edge flags, pointer/count update, the
  // FWFT prefetch pipeline (RAM read register -> output stage) and flag decode.
  always_comb begin
    wr_acc      = wr_en && !full_q;
    rd_acc      = rd_en && !empty_q;
    ram_rd      = 1'b0;
    mid_to_out  = 1'b0;
    mid_valid_d = mid_valid_q;
    mid_data_d  = mid_data_q;
    dout_d      = dout_q;
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    wptr_d      = wptr_q + CW'(wr_acc);
    if (FWFT != 0) begin
      // The RAM stage advances into the output stage whenever the output is
      // free or being popped; the RAM is re-read as soon as its stage frees up.
      mid_to_out = mid_valid_q && (empty_q || rd_acc);
      ram_rd     = (wptr_q != rptr_q) && (!mid_valid_q || mid_to_out);
      if (mid_to_out) begin
        dout_d = mid_data_q;
      end
      if (ram_rd) begin
        mid_valid_d = 1'b1;
        mid_data_d  = mem[raddr];
      end else if (mid_to_out) begin
        mid_valid_d = 1'b0;
      end
      empty_d = !(mid_to_out || (!empty_q && !rd_acc));
    end else begin
      ram_rd = rd_acc;
      if (rd_acc) begin
        dout_d = mem[raddr];
      end
      empty_d = (count_d == '0);
    end
    rptr_d = rptr_q + CW'(ram_rd);
    full_d = (count_d == DEPTH_CNT);
    af_d   = (count_d >= AF_CNT);
    ae_d   = (count_d <= AE_CNT);
    ovf_d  = wr_en && full_q;
    unf_d  = rd_en && empty_q;
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[waddr] <= din;
    end
  end

  // All control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      mid_data_q  <= '0;
      mid_valid_q <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      mid_data_q  <= mid_data_d;
      mid_valid_q <= mid_valid_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign dout         = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_ram_fifo.sv
// tb_ram_fifo: directed checks of ram_fifo in standard mode (default depth),
// a small depth-4 instance for wrap-around, and an FWFT instance.
module tb_ram_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Standard mode, default depth 512
  logic [7:0] s_din = '0;
  logic       s_wr = 1'b0, s_rd = 1'b0;
  logic [7:0] s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [9:0] s_count;

  // Standard mode, depth 4
  logic [7:0] w_din = '0;
  logic       w_wr = 1'b0, w_rd = 1'b0;
  logic [7:0] w_dout;
  logic       w_full, w_empty, w_af, w_ae, w_ovf, w_unf;
  logic [2:0] w_count;

  // FWFT mode, default depth 512
  logic [7:0] f_din = '0;
  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [9:0] f_count;

  int checks = 0;
  int errors = 0;

  ram_fifo u_std (
    .clk(clk), .reset(reset), .din(s_din), .wr_en(s_wr), .rd_en(s_rd),
    .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  ram_fifo #(.ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) u_wrap (
    .clk(clk), .reset(reset), .din(w_din), .wr_en(w_wr), .rd_en(w_rd),
    .dout(w_dout), .full(w_full), .empty(w_empty), .almost_full(w_af),
    .almost_empty(w_ae), .count(w_count), .overflow(w_ovf), .underflow(w_unf)
  );

  ram_fifo #(.FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Drive one instance's inputs for exactly one rising edge, then settle 1 ns
  task automatic applyStimulus(input int which, input logic wr, input logic rd,
                               input logic [7:0] data);
    case (which)
      0: begin s_wr = wr; s_rd = rd; s_din = data; end
      1: begin w_wr = wr; w_rd = rd; w_din = data; end
      default: begin f_wr = wr; f_rd = rd; f_din = data; end
    endcase
    @(posedge clk);
    #1;
    s_wr = 1'b0; s_rd = 1'b0;
    w_wr = 1'b0; w_rd = 1'b0;
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  // One comparison point: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset between phases with a clock-aligned release
  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state of the default instance
    #12;
    checkOutput("rst_count", 32'(s_count), 32'd0);
    checkOutput("rst_empty", 32'(s_empty), 32'd1);
    checkOutput("rst_full", 32'(s_full), 32'd0);
    checkOutput("rst_ae", 32'(s_ae), 32'd1);
    checkOutput("rst_af", 32'(s_af), 32'd0);
    checkOutput("rst_dout", 32'(s_dout), 32'd0);
    checkOutput("rst_ovf", 32'(s_ovf), 32'd0);
    checkOutput("rst_unf", 32'(s_unf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill 1..512 and watch the flags at their thresholds
    for (int i = 1; i <= 512; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 8'(i));
      if (i == 1) begin
        checkOutput("fill_empty1", 32'(s_empty), 32'd0);
        checkOutput("fill_count1", 32'(s_count), 32'd1);
      end
      if (i == 4) checkOutput("fill_ae4", 32'(s_ae), 32'd1);
      if (i == 5) checkOutput("fill_ae5", 32'(s_ae), 32'd0);
      if (i == 507) checkOutput("fill_af507", 32'(s_af), 32'd0);
      if (i == 508) checkOutput("fill_af508", 32'(s_af), 32'd1);
      if (i == 511) checkOutput("fill_full511", 32'(s_full), 32'd0);
      if (i == 512) begin
        checkOutput("fill_full512", 32'(s_full), 32'd1);
        checkOutput("fill_count512", 32'(s_count), 32'd512);
      end
    end
    applyStimulus(0, 1'b1, 1'b0, 8'hFF);
    checkOutput("ovf_pulse", 32'(s_ovf), 32'd1);
    checkOutput("ovf_count", 32'(s_count), 32'd512);
    applyStimulus(0, 1'b0, 1'b0, 8'h00);
    checkOutput("ovf_clear", 32'(s_ovf), 32'd0);

    // Read and write together while full: read wins, write rejected
    applyStimulus(0, 1'b1, 1'b1, 8'hEE);
    checkOutput("rwfull_ovf", 32'(s_ovf), 32'd1);
    checkOutput("rwfull_count", 32'(s_count), 32'd511);
    checkOutput("rwfull_dout", 32'(s_dout), 32'd1);
    checkOutput("rwfull_full", 32'(s_full), 32'd0);

    // Standard read latency and underflow
    pulseReset();
    applyStimulus(0, 1'b1, 1'b0, 8'hA5);
    applyStimulus(0, 1'b1, 1'b0, 8'h3C);
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("std_rd1", 32'(s_dout), 32'hA5);
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("std_rd2", 32'(s_dout), 32'h3C);
    checkOutput("std_empty", 32'(s_empty), 32'd1);
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("std_unf", 32'(s_unf), 32'd1);
    checkOutput("std_hold", 32'(s_dout), 32'h3C);

    // Simultaneous read and write at count 2 keeps order
    pulseReset();
    applyStimulus(0, 1'b1, 1'b0, 8'h10);
    applyStimulus(0, 1'b1, 1'b0, 8'h20);
    applyStimulus(0, 1'b1, 1'b1, 8'h30);
    checkOutput("rw2_count", 32'(s_count), 32'd2);
    checkOutput("rw2_dout", 32'(s_dout), 32'h10);
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("rw2_rd2", 32'(s_dout), 32'h20);
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("rw2_rd3", 32'(s_dout), 32'h30);
    checkOutput("rw2_count0", 32'(s_count), 32'd0);

    // Reset mid-stream with five words stored
    pulseReset();
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, 1'b0, 8'(8'h51 + i));
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("mid_count5", 32'(s_count), 32'd5);
    checkOutput("mid_dout", 32'(s_dout), 32'h51);
    reset = 1'b1;
    #1;
    checkOutput("async_count", 32'(s_count), 32'd0);
    checkOutput("async_empty", 32'(s_empty), 32'd1);
    checkOutput("async_dout", 32'(s_dout), 32'd0);
    checkOutput("async_ae", 32'(s_ae), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 1'b1, 8'h00);
    checkOutput("async_unf", 32'(s_unf), 32'd1);

    // Wrap-around on the depth-4 instance at occupancy 3
    for (int i = 0; i < 3; i++) applyStimulus(1, 1'b1, 1'b0, 8'(i));
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1, 1'b1, 1'b1, 8'(j + 3));
      checkOutput($sformatf("wrap_dout%0d", j), 32'(w_dout), 32'(j));
      checkOutput($sformatf("wrap_count%0d", j), 32'(w_count), 32'd3);
      checkOutput($sformatf("wrap_full%0d", j), 32'(w_full), 32'd0);
    end
    for (int j = 10; j < 13; j++) begin
      applyStimulus(1, 1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("wrap_drain%0d", j), 32'(w_dout), 32'(j));
    end
    checkOutput("wrap_empty", 32'(w_empty), 32'd1);

    // FWFT: write 0x11 at k, 0x22 at k+1, pop at k+3
    applyStimulus(2, 1'b1, 1'b0, 8'h11);
    checkOutput("fw_k_empty", 32'(f_empty), 32'd1);
    checkOutput("fw_k_count", 32'(f_count), 32'd1);
    applyStimulus(2, 1'b1, 1'b0, 8'h22);
    checkOutput("fw_k1_empty", 32'(f_empty), 32'd1);
    applyStimulus(2, 1'b0, 1'b0, 8'h00);
    checkOutput("fw_k2_empty", 32'(f_empty), 32'd0);
    checkOutput("fw_k2_dout", 32'(f_dout), 32'h11);
    checkOutput("fw_k2_count", 32'(f_count), 32'd2);
    applyStimulus(2, 1'b0, 1'b1, 8'h00);
    checkOutput("fw_k3_dout", 32'(f_dout), 32'h22);
    checkOutput("fw_k3_count", 32'(f_count), 32'd1);
    applyStimulus(2, 1'b0, 1'b1, 8'h00);
    checkOutput("fw_pop_empty", 32'(f_empty), 32'd1);
    applyStimulus(2, 1'b0, 1'b1, 8'h00);
    checkOutput("fw_unf", 32'(f_unf), 32'd1);

    // FWFT back-to-back pops, one word per cycle
    applyStimulus(2, 1'b1, 1'b0, 8'h31);
    applyStimulus(2, 1'b1, 1'b0, 8'h32);
    applyStimulus(2, 1'b1, 1'b0, 8'h33);
    applyStimulus(2, 1'b0, 1'b0, 8'h00);
    checkOutput("fw_b2b_head", 32'(f_dout), 32'h31);
    applyStimulus(2, 1'b0, 1'b1, 8'h00);
    checkOutput("fw_b2b_1", 32'(f_dout), 32'h32);
    checkOutput("fw_b2b_cnt1", 32'(f_count), 32'd2);
    applyStimulus(2, 1'b0, 1'b1, 8'h00);
    checkOutput("fw_b2b_2", 32'(f_dout), 32'h33);
    checkOutput("fw_b2b_cnt2", 32'(f_count), 32'd1);
    applyStimulus(2, 1'b0, 1'b1, 8'h00);
    checkOutput("fw_b2b_empty", 32'(f_empty), 32'd1);
    checkOutput("fw_b2b_cnt3", 32'(f_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
